// File: rtl/regfile_wb_scheduler_pkg.sv
// Register-file constants, requester ids and a popcount helper.
// Shared by the write-back scheduler, decoder and ALU wrappers.
package regfile_pkg;

  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 8;
  localparam int NREG        = 16;
  localparam int RF_SEL_BITS = 4;
  localparam int CNT_W       = 5;

  localparam logic [RF_SEL_BITS-1:0] ZERO_REG = 4'd15;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LD  = 1'b1
  } req_id_e;

  function automatic logic [CNT_W-1:0] popcount16(input logic [NREG-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NREG; i++) begin
      n = n + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Write-back request, issue/read-hazard and register-file write pins of the scheduler.
// slave = scheduler side, master = decoder/ALU/load side.
interface regfile_wb_scheduler_if;
  import regfile_pkg::*;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              stall;
  logic              rf_w;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  busy_cnt;

  modport master (
    output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
           iss_valid, iss_addr, rd_addr1, rd_addr2,
    input  alu_ready, ld_ready, stall, rf_w, rf_waddr, rf_wdata, busy_cnt
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
           iss_valid, iss_addr, rd_addr1, rd_addr2,
    output alu_ready, ld_ready, stall, rf_w, rf_waddr, rf_wdata, busy_cnt
  );

endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter, grant is combinational from req and the priority pointer.
// On contention the requester not granted last wins; the pointer moves only when a grant is given.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  req_id_e prio_q, prio_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= REQ_ALU;
    end else begin
      prio_q <= prio_d;
    end
  end

  always_comb begin
    gnt_o  = 2'b00;
    prio_d = prio_q;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (prio_q == REQ_ALU) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
    if (gnt_o[0]) begin
      prio_d = REQ_LD;
    end else if (gnt_o[1]) begin
      prio_d = REQ_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between ALU and load streams; winning write appears on rf_w one cycle after transfer.
// Readies are combinational and mutually exclusive; busy scoreboard drives the decoder read stall.
module regfile_wb_scheduler
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  regfile_wb_scheduler_if.slave bus
);

  logic [1:0]             gnt;
  logic [RF_SEL_BITS-1:0] win_sel;
  logic [DATA_W-1:0]      win_data;
  logic                   wr_en;

  logic                   rf_w_q, rf_w_d;
  logic [RF_SEL_BITS-1:0] rf_wsel_q, rf_wsel_d;
  logic [DATA_W-1:0]      rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]        busy_q, busy_d;
  logic [CNT_W-1:0]       busy_cnt_q, busy_cnt_d;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({bus.ld_valid, bus.alu_valid}),
    .gnt_o (gnt)
  );

  assign bus.alu_ready = gnt[0];
  assign bus.ld_ready  = gnt[1];

  always_comb begin
    win_sel    = gnt[1] ? bus.ld_addr[RF_SEL_BITS-1:0] : bus.alu_addr[RF_SEL_BITS-1:0];
    win_data   = gnt[1] ? bus.ld_data : bus.alu_data;
    // Writes to the hard-zero register are accepted but never reach the file.
    wr_en      = (|gnt) && (win_sel != ZERO_REG);
    rf_w_d     = wr_en;
    rf_wsel_d  = rf_wsel_q;
    rf_wdata_d = rf_wdata_q;
    if (wr_en) begin
      rf_wsel_d  = win_sel;
      rf_wdata_d = win_data;
    end

    // Clear first so a same-edge issue to the committing register keeps it busy.
    busy_d = busy_q;
    if (rf_w_q) begin
      busy_d[rf_wsel_q] = 1'b0;
    end
    if (bus.iss_valid && (bus.iss_addr[RF_SEL_BITS-1:0] != ZERO_REG)) begin
      busy_d[bus.iss_addr[RF_SEL_BITS-1:0]] = 1'b1;
    end
    busy_cnt_d = popcount16(busy_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_w_q     <= 1'b0;
      rf_wsel_q  <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      rf_w_q     <= rf_w_d;
      rf_wsel_q  <= rf_wsel_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign bus.rf_w     = rf_w_q;
  assign bus.rf_waddr = {{(ADDR_W-RF_SEL_BITS){1'b0}}, rf_wsel_q};
  assign bus.rf_wdata = rf_wdata_q;
  assign bus.busy_cnt = busy_cnt_q;
  assign bus.stall    = busy_q[bus.rd_addr1[RF_SEL_BITS-1:0]] | busy_q[bus.rd_addr2[RF_SEL_BITS-1:0]];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios then random traffic against a reference model.
module tb_regfile_wb_scheduler;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_scheduler_if bus();

  regfile_wb_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int due;
    int sel;
    int data;
  } wr_t;

  wr_t exp_q[$];

  // Reference model: busy flags, arbitration preference, write currently on the file pins.
  int busy_m[16];
  int prio_m;
  int cur_vld_m;
  int cur_sel_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: whenever a write is due, the file pins must show it; otherwise rf_w stays low.
  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      chk("both_ready", int'(bus.alu_ready & bus.ld_ready), 0);
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        chk("rf_w", int'(bus.rf_w), 1);
        chk("rf_waddr", int'(bus.rf_waddr), e.sel);
        chk("rf_wdata", int'(bus.rf_wdata), e.data);
      end else begin
        chk("rf_w_idle", int'(bus.rf_w), 0);
      end
    end
  end

  // Model: predicts grants, pushes expected writes, tracks busy registers.
  always @(negedge clk) begin
    int g, sel, data, cnt;
    int nb[16];
    if (rst) begin
      foreach (busy_m[i]) busy_m[i] = 0;
      prio_m    = 0;
      cur_vld_m = 0;
      cur_sel_m = 0;
      exp_q.delete();
    end else begin
      cnt = 0;
      foreach (busy_m[i]) cnt += busy_m[i];
      chk("stall", int'(bus.stall), busy_m[bus.rd_addr1 % 16] | busy_m[bus.rd_addr2 % 16]);
      chk("busy_cnt", int'(bus.busy_cnt), cnt);

      g = -1;
      if (bus.alu_valid && bus.ld_valid) g = prio_m;
      else if (bus.alu_valid)            g = 0;
      else if (bus.ld_valid)             g = 1;
      chk("alu_ready", int'(bus.alu_ready), int'(g == 0));
      chk("ld_ready", int'(bus.ld_ready), int'(g == 1));

      nb = busy_m;
      if (cur_vld_m != 0) nb[cur_sel_m] = 0;
      if (bus.iss_valid && (bus.iss_addr % 16) != 15) nb[bus.iss_addr % 16] = 1;

      cur_vld_m = 0;
      if (g >= 0) begin
        prio_m = 1 - g;
        sel  = (g == 1) ? int'(bus.ld_addr % 16) : int'(bus.alu_addr % 16);
        data = (g == 1) ? int'(bus.ld_data) : int'(bus.alu_data);
        if (sel != 15) begin
          exp_q.push_back('{due: cyc + 1, sel: sel, data: data});
          cur_vld_m = 1;
          cur_sel_m = sel;
        end
      end
      busy_m = nb;
    end
  end

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.iss_valid = 1'b0;
  endtask

  initial begin
    int grant_alu[4];
    logic a_acc, l_acc;

    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_addr  = '0; bus.ld_data  = '0;
    bus.iss_valid = 1'b0; bus.iss_addr = '0;
    bus.rd_addr1  = '0;   bus.rd_addr2 = '0;

    #1;
    chk("rst_rf_w", int'(bus.rf_w), 0);
    chk("rst_rf_waddr", int'(bus.rf_waddr), 0);
    chk("rst_rf_wdata", int'(bus.rf_wdata), 0);
    chk("rst_busy_cnt", int'(bus.busy_cnt), 0);
    chk("rst_stall", int'(bus.stall), 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single ALU write to r3.
    bus.alu_valid = 1'b1; bus.alu_addr = 8'h03; bus.alu_data = 8'hA5;
    #1 chk("t2_alu_ready", int'(bus.alu_ready), 1);
    tick();
    bus.alu_valid = 1'b0;
    chk("t2_rf_w", int'(bus.rf_w), 1);
    chk("t2_rf_waddr", int'(bus.rf_waddr), 8'h03);
    chk("t2_rf_wdata", int'(bus.rf_wdata), 8'hA5);
    tick();
    chk("t2_rf_w_off", int'(bus.rf_w), 0);

    // Scoreboard: issue r5, then a load commits r5.
    bus.iss_valid = 1'b1; bus.iss_addr = 8'h05; bus.rd_addr1 = 8'h05;
    tick();
    bus.iss_valid = 1'b0;
    chk("t4_stall_set", int'(bus.stall), 1);
    chk("t4_cnt_set", int'(bus.busy_cnt), 1);
    bus.ld_valid = 1'b1; bus.ld_addr = 8'h05; bus.ld_data = 8'h5A;
    tick();
    bus.ld_valid = 1'b0;
    chk("t4_rf_w", int'(bus.rf_w), 1);
    chk("t4_stall_hold", int'(bus.stall), 1);
    tick();
    chk("t4_stall_clr", int'(bus.stall), 0);
    chk("t4_cnt_clr", int'(bus.busy_cnt), 0);

    // Contention: ALU r1 and LD r2 held for four cycles.
    bus.rd_addr1 = 8'h00;
    bus.alu_valid = 1'b1; bus.alu_addr = 8'h01; bus.alu_data = 8'h11;
    bus.ld_valid  = 1'b1; bus.ld_addr  = 8'h02; bus.ld_data  = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1 grant_alu[i] = int'(bus.alu_ready);
      chk("t3_ld_ready", int'(bus.ld_ready), 1 - grant_alu[i]);
      tick();
    end
    idle();
    chk("t3_grant0", grant_alu[0], 1);
    chk("t3_grant1", grant_alu[1], 0);
    chk("t3_grant2", grant_alu[2], 1);
    chk("t3_grant3", grant_alu[3], 0);
    tick();

    // Zero register: accepted, never written, never busy.
    bus.alu_valid = 1'b1; bus.alu_addr = 8'h0F; bus.alu_data = 8'hFF;
    #1 chk("t5_alu_ready", int'(bus.alu_ready), 1);
    tick();
    bus.alu_valid = 1'b0;
    chk("t5_rf_w", int'(bus.rf_w), 0);
    bus.iss_valid = 1'b1; bus.iss_addr = 8'h0F; bus.rd_addr2 = 8'h0F;
    tick();
    bus.iss_valid = 1'b0;
    chk("t5_stall", int'(bus.stall), 0);
    chk("t5_cnt", int'(bus.busy_cnt), 0);

    // Set/clear collision on r7.
    bus.alu_valid = 1'b1; bus.alu_addr = 8'h07; bus.alu_data = 8'h77;
    tick();
    bus.alu_valid = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_addr = 8'h07;
    tick();
    bus.iss_valid = 1'b0; bus.rd_addr2 = 8'h17;
    #1;
    chk("t6_stall", int'(bus.stall), 1);
    chk("t6_cnt", int'(bus.busy_cnt), 1);
    tick();

    // Mid-run reset with busy = 16'h00F0 and a write on the pins.
    bus.rd_addr1 = 8'h04; bus.rd_addr2 = 8'h00;
    bus.iss_valid = 1'b1; bus.iss_addr = 8'h04;
    tick();
    bus.iss_addr = 8'h05;
    tick();
    bus.iss_addr = 8'h06;
    bus.alu_valid = 1'b1; bus.alu_addr = 8'h01; bus.alu_data = 8'h3C;
    tick();
    idle();
    chk("t1_pre_cnt", int'(bus.busy_cnt), 4);
    chk("t1_pre_rf_w", int'(bus.rf_w), 1);
    chk("t1_pre_stall", int'(bus.stall), 1);
    #1 rst = 1'b1;
    #1;
    chk("t1_rf_w", int'(bus.rf_w), 0);
    chk("t1_busy_cnt", int'(bus.busy_cnt), 0);
    chk("t1_stall", int'(bus.stall), 0);
    tick();
    rst = 1'b0;
    tick();

    // Random traffic; a pending request holds until accepted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a_acc = bus.alu_valid & bus.alu_ready;
      l_acc = bus.ld_valid & bus.ld_ready;
      @(posedge clk);
      #1;
      if (!bus.alu_valid || a_acc) begin
        bus.alu_valid = ($urandom_range(0, 99) < 60);
        bus.alu_addr  = 8'($urandom_range(0, 255));
        bus.alu_data  = 8'($urandom_range(0, 255));
      end
      if (!bus.ld_valid || l_acc) begin
        bus.ld_valid = ($urandom_range(0, 99) < 50);
        bus.ld_addr  = 8'($urandom_range(0, 255));
        bus.ld_data  = 8'($urandom_range(0, 255));
      end
      bus.iss_valid = ($urandom_range(0, 99) < 35);
      bus.iss_addr  = 8'($urandom_range(0, 255));
      bus.rd_addr1  = 8'($urandom_range(0, 255));
      bus.rd_addr2  = 8'($urandom_range(0, 255));
    end

    idle();
    tick(); tick(); tick();
    chk("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
